// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first,
// computed as a + ~b + 1 through a single full-adder cell and a carry flip-flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             over_flow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    // Full-adder cell on the current LSBs; the subtrahend bit is inverted here.
    logic             ai, nbi, s, cout;
    logic [WIDTH-1:0] sh;

    always_comb begin
        ai   = a_q[0];
        nbi  = ~b_q[0];
        s    = ai ^ nbi ^ carry_q;
        cout = (ai & nbi) | (carry_q & (ai ^ nbi));
        sh   = {s, res_q};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = cout;
                cnt_d   = cnt_q + CW'(1);
                res_d   = sh[WIDTH-1:1];
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit: ai/b_q[0] are the operand sign bits, s is the result sign.
                    diff_d   = sh;
                    borrow_d = ~cout;
                    ovf_d    = (ai ^ b_q[0]) & (s ^ ai);
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign over_flow = ovf_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases, handshake timing,
// reset abort and a randomized sweep against an integer-arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] diff;
    logic         borrow, over_flow, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    // Last result the bench expects the outputs to be holding.
    logic [W-1:0] pd = '0;
    logic         pb = 1'b0;
    logic         po = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .diff(diff), .borrow(borrow), .over_flow(over_flow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] ed, output logic eb, output logic eo);
        int ua, ub, sa, sb, sr;
        ua = int'(av);
        ub = int'(bv);
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        sr = sa - sb;
        ed = W'((ua - ub + (1 << W)) % (1 << W));
        eb = (ua < ub);
        eo = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    endtask

    // Issue one op at the current negedge; returns at the negedge inside the DONE cycle.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
        logic [W-1:0] ed;
        logic         eb, eo;
        int           j, nbusy;
        bit           held;
        model(av, bv, ed, eb, eo);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        j = 0;
        nbusy = 0;
        held = 1'b1;
        while (done !== 1'b1 && j < 4 * W) begin
            if (busy === 1'b1) nbusy++;
            if (diff !== pd || borrow !== pb || over_flow !== po) held = 1'b0;
            @(negedge clk);
            if (hold) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            j++;
        end
        start = 1'b0;
        chk("latency", 32'(j), 32'(W));
        chk("busy_cycles", 32'(nbusy), 32'(W));
        chk("prev_result_held", 32'(held), 32'd1);
        chk("diff", 32'(diff), 32'(ed));
        chk("borrow", 32'(borrow), 32'(eb));
        chk("over_flow", 32'(over_flow), 32'(eo));
        pd = ed;
        pb = eb;
        po = eo;
    endtask

    // One cycle with no start: done must have dropped, no busy, result held.
    task automatic idle_step();
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_hold_diff", 32'(diff), 32'(pd));
    endtask

    initial begin
        bit saw_done;

        repeat (2) @(negedge clk);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_flags", 32'({borrow, over_flow, busy, done}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_done", 32'(done), 32'd0);

        do_op(8'd10, 8'd4, 1'b0);
        chk("t1_diff_abs", 32'(diff), 32'h06);
        idle_step();
        do_op(8'd4, 8'd10, 1'b0);
        chk("t2_diff_abs", 32'(diff), 32'hFA);
        idle_step();
        do_op(8'h00, 8'h00, 1'b0);
        idle_step();
        do_op(8'h80, 8'h01, 1'b0);
        chk("t3_ovf_abs", 32'({borrow, over_flow}), 32'b01);
        idle_step();
        do_op(8'h7F, 8'hFF, 1'b0);
        chk("t3_both_abs", 32'({diff, borrow, over_flow}), 32'({8'h80, 2'b11}));
        idle_step();

        // start held high through RUN with changing operands
        do_op(8'h3C, 8'h5A, 1'b1);
        idle_step();

        // back-to-back: second op issued in the DONE cycle of the first
        do_op(8'hC8, 8'h21, 1'b0);
        do_op(8'h55, 8'h0F, 1'b0);
        chk("t5_diff_abs", 32'(diff), 32'h46);
        idle_step();

        // reset mid-RUN
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_flags", 32'({borrow, over_flow, busy, done}), 32'd0);
        pd = '0;
        pb = 1'b0;
        po = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        do_op(8'h91, 8'hA7, 1'b0);
        idle_step();

        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) idle_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
